// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and default sizes for the on-chip memory arbiter.
package onchip_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 41000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_t;

  typedef logic port_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Requester-side handshake bundle; one instance per requester port.
interface onchip_mem_arbiter_if
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic                  ack;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rvalid, rdata, err
  );

endinterface

// File: rtl/onchip_mem_arbiter_arb_pick.sv
// Two-input grant selector. Fixed priority (port 0 wins) by default;
// define ONCHIP_ARB_ROUND_ROBIN_EN to alternate against the last grant.
module arb_pick
  import onchip_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
  input  port_t      last,
`endif
  output logic       grant_vld,
  output port_t      grant_idx
);

  // Choose the winning port; index is don't-care when nobody asks
  always_comb begin
    grant_vld = |req;
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    if (req == 2'b11) grant_idx = ~last;
    else              grant_idx = ~req[0];
`else
    grant_idx = ~req[0];
`endif
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous on-chip memory.
// Optional macro: ONCHIP_ARB_ROUND_ROBIN_EN (round-robin on contention).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting; grant (ack) is combinational from req
// ST_ACCESS | memory bus driven from the accepted request
// ST_RDATA  | read data arrives from memory, registered into rdata
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave rq0,
  onchip_mem_arbiter_if.slave rq1,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int          BE_W    = DATA_W / 8;
  localparam logic [31:0] DEPTH_V = 32'(DEPTH);

  state_t              state;
  port_t               cur_port;
  logic                cur_we;
  logic                cur_oor;
  logic [1:0]          rvalid_q;
  logic [1:0]          err_q;
  logic [DATA_W-1:0]   rdata_q [2];

  logic                grant_vld;
  port_t               grant_idx;
  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BE_W-1:0]     sel_be;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_oor;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
  port_t               last_q;
`endif

  arb_pick u_pick (
    .req       ({rq1.req, rq0.req}),
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    .last      (last_q),
`endif
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Payload of the port that would be granted this cycle
  always_comb begin
    sel_we    = grant_idx ? rq1.we    : rq0.we;
    sel_addr  = grant_idx ? rq1.addr  : rq0.addr;
    sel_be    = grant_idx ? rq1.be    : rq0.be;
    sel_wdata = grant_idx ? rq1.wdata : rq0.wdata;
    sel_oor   = (32'(sel_addr) >= DEPTH_V);
  end

  // Gated by reset_n so ack also drops the instant reset asserts
  assign accept = reset_n && (state == ST_IDLE) && grant_vld;

  assign rq0.ack    = accept && (grant_idx == 1'b0);
  assign rq1.ack    = accept && (grant_idx == 1'b1);
  assign rq0.rvalid = rvalid_q[0];
  assign rq1.rvalid = rvalid_q[1];
  assign rq0.err    = err_q[0];
  assign rq1.err    = err_q[1];
  assign rq0.rdata  = rdata_q[0];
  assign rq1.rdata  = rdata_q[1];

  // Sequencer: accept, drive memory for one cycle, then return read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cur_port       <= 1'b0;
      cur_we         <= 1'b0;
      cur_oor        <= 1'b0;
      rvalid_q       <= '0;
      err_q          <= '0;
      rdata_q[0]     <= '0;
      rdata_q[1]     <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
      last_q         <= 1'b1;
`endif
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state          <= ST_ACCESS;
            cur_port       <= grant_idx;
            cur_we         <= sel_we;
            cur_oor        <= sel_oor;
            mem_chipselect <= ~sel_oor;
            mem_write      <= sel_we;
            mem_address    <= sel_addr;
            mem_byteenable <= sel_be;
            mem_writedata  <= sel_wdata;
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
            last_q         <= grant_idx;
`endif
          end
        end
        ST_ACCESS: begin
          mem_chipselect <= 1'b0;
          mem_write      <= 1'b0;
          mem_address    <= '0;
          mem_byteenable <= '0;
          mem_writedata  <= '0;
          if (cur_we) begin
            state           <= ST_IDLE;
            err_q[cur_port] <= cur_oor;
          end else begin
            state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          state              <= ST_IDLE;
          rvalid_q[cur_port] <= 1'b1;
          err_q[cur_port]    <= cur_oor;
          rdata_q[cur_port]  <= cur_oor ? '0 : mem_readdata;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-enable width DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 41000, number of valid memory words.
REQ-004 SHALL have ports: clk in 1, sole clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have, per requester p in {0,1}: req_p in 1; we_p in 1; addr_p in ADDR_W; be_p in DATA_W/8; wdata_p in DATA_W.
REQ-006 SHALL have, per requester p: ack_p out 1 (request accepted); rvalid_p out 1; rdata_p out DATA_W; err_p out 1.
REQ-007 SHALL have memory-side ports: mem_chipselect out 1; mem_write out 1; mem_address out ADDR_W; mem_byteenable out DATA_W/8; mem_writedata out DATA_W; mem_readdata in DATA_W (valid one cycle after address is presented).

Function
REQ-008 SHALL implement the FSM IDLE -> ACCESS -> (read) RDATA -> IDLE, or IDLE -> ACCESS -> IDLE (write).
REQ-009 In IDLE with any req_p high, SHALL assert ack_p combinationally for exactly one granted port, latch we/addr/be/wdata and the port index, and go to ACCESS.
REQ-010 In ACCESS, SHALL drive mem_address, mem_byteenable, mem_writedata and mem_write=we from the latched values, with mem_chipselect=1 only if the latched addr < DEPTH.
REQ-011 A read SHALL enter RDATA, register mem_readdata into rdata_p of the latched port, and pulse rvalid_p for one cycle at acceptance+3.
REQ-012 A write SHALL return to IDLE after ACCESS; a new request can then be acked at acceptance+2.
REQ-013 Out-of-range access (addr >= DEPTH) SHALL drive no memory access: read -> rvalid_p with rdata_p=0 and err_p at acceptance+3; write -> one-cycle err_p pulse at acceptance+2.
REQ-014 rdata_p SHALL hold its last value until the next read completion on that port.
REQ-015 ack_p SHALL never be high outside IDLE; at most one ack per cycle.
REQ-016 Requester SHALL hold req and payload until ack; req dropped before ack is legal and leaves no effect.
REQ-017 Memory outputs SHALL be 0 whenever not in ACCESS.

Reset
REQ-018 reset_n low SHALL immediately force IDLE and all outputs (ack, rvalid, err, rdata, mem_*) to 0, abandoning any in-flight transaction without further memory access.
REQ-019 Reset SHALL set last-granted pointer to port 1, so port 0 wins the first contention.

Configuration
REQ-020 With ONCHIP_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL grant the port not granted most recently; undefined, port 0 SHALL always win (fixed priority), pointer logic absent.

Structure
REQ-021 Package onchip_arb_pkg SHALL hold the FSM state enum, port-index typedef, and default parameter constants.
REQ-022 Grant selection SHALL be a sub-module arb_pick (2-input, fixed/round-robin per macro).

Verification
REQ-023 Port 0 write addr=0x0010 be=0xF wdata=0xCAFEF00D, then read 0x0010 -> ack same cycle, mem_write one cycle later, rvalid_0 at +3 with rdata_0=0xCAFEF00D, err_0=0.
REQ-024 Both ports read every cycle, round-robin build -> grants alternate 0,1,0,1; fixed build -> port 1 never acked while req_0 held.
REQ-025 Byte-enable: write 0xFFFFFFFF, then write be=0x2 data 0x00000000 -> readback 0xFFFF00FF.
REQ-026 Read addr=41000 -> mem_chipselect stays 0, rvalid with rdata=0 and err=1; write addr=0xFFFF -> err pulse at +2, memory unchanged.
REQ-027 reset_n asserted in ACCESS of a read -> no rvalid, outputs 0 at once; after release, port 0 wins first contention.
